branch_predict_unit: RTL
========================

Name: branch_predict_unit

Overview:
- Parametrised successor to the pipeline's branch/jump opcode decoder.
- In IF: decodes beq/bne/j/jal/syscall from the fetched word and predicts direction and target, using a table of saturating counters indexed by PC (BHT).
- In EX: takes the resolved outcome, trains the BHT, and issues a registered one-cycle redirect/flush on a mispredict.
- Keeps saturating branch and mispredict statistics counters.

Parameters:
- BHT_DEPTH, 64, number of BHT entries; power of two, ≥2; IDX_W = log2(BHT_DEPTH).
- CTR_W, 2, width of each saturating counter; ≥1.
- STAT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- if_valid  in  1  IF holds a valid instruction
- if_pc  in  32  PC of the IF instruction
- if_instr  in  32  fetched instruction word
- if_branch  out  1  beq or bne decoded (combinational)
- if_jump  out  1  j or jal decoded
- if_ecall  out  1  syscall decoded (opcode 000000, funct 001100)
- if_beq  out  1  beq decoded
- if_bne  out  1  bne decoded
- pred_taken  out  1  predicted taken
- pred_target  out  32  predicted next PC
- ex_valid  in  1  EX holds a valid branch/jump resolution
- ex_branch  in  1  EX instruction is a conditional branch
- ex_pc  in  32  PC of the EX instruction
- ex_pred_taken  in  1  prediction carried down the pipe
- ex_taken  in  1  actual outcome
- ex_target  in  32  actual taken target
- redirect_valid  out  1  mispredict redirect; also the flush for IF/ID/EX
- redirect_pc  out  32  correct next PC
- branch_count  out  STAT_W  resolved conditional branches
- mispredict_count  out  STAT_W  mispredicted conditional branches

Behaviour:
- **Decode (combinational).**
  - All decode outputs are 0 when if_valid=0.
  - Opcodes: 000100 = beq, 000101 = bne, 000010 = j, 000011 = jal.
  - Any other opcode gives all zeros.
- **Prediction (combinational from BHT state).**
  - Index = if_pc[IDX_W+1:2].
  - Branch: pred_taken = counter MSB; pred_target = if_pc+4 + (sign-extended instr[15:0] << 2) when taken, else if_pc+4.
  - Jump: pred_taken=1; pred_target = {pc4[31:28], instr[25:0], 2'b00}.
  - Otherwise: pred_taken=0; pred_target = if_pc+4.
  - if_ecall never redirects.
  - All additions are 32-bit modulo; wrap-around is silent.
- **Training.**
  - Trigger: ex_valid & ex_branch & !redirect_valid.
  - Entry ex_pc[IDX_W+1:2] increments when ex_taken, else decrements.
  - Saturates at 2^CTR_W−1 and at 0.
  - Jumps never train.
- **Read/write collision.** If IF and EX hit the same index in the same cycle, IF sees the pre-update value (read-before-write).
- **Mispredict.**
  - Condition: ex_valid & !redirect_valid & (ex_pred_taken != ex_taken), or a taken branch whose carried target ≠ ex_target. The target check is realised by the pipeline setting ex_pred_taken=0 if its target differed.
  - On the next edge: redirect_valid=1 for exactly one cycle; redirect_pc = ex_taken ? ex_target : ex_pc+4.
  - Latency: EX cycle N → redirect_valid in cycle N+1.
- **Squash.** While redirect_valid=1, ex_valid is ignored for training, statistics and mispredict detection, because EX holds a wrong-path instruction. So two redirects are never back-to-back.
- **Statistics.**
  - branch_count increments on every qualifying training event.
  - mispredict_count increments when a qualifying conditional branch mispredicts.
  - Both saturate at all-ones.
  - Jump mispredicts (which cannot occur when the pipeline is correct) are redirected but not counted.
- **Reset.**
  - Every BHT entry = weakly-not-taken (2^(CTR_W−1)−1, i.e. 01 for CTR_W=2).
  - redirect_valid=0, redirect_pc=0, both counters=0.
  - Reset during an active redirect cancels it on the same edge.
  - All entries are initialised in one cycle (register array, no sequencer).

Decomposition:
- **Package branch_pkg:**
  - opcode constants OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_RTYPE;
  - FUNCT_SYSCALL;
  - functions for the counter reset value and saturating inc/dec.
- **Sub-module bht_table:** parameters DEPTH and CTR_W; one async read port, one sync write port with enable; synchronous reset to the weak-not-taken value. The top level holds decode, target arithmetic, redirect register and statistics.

Test Plan:
1. **Reset then fetch.** rst 2 cycles, then fetch beq at 0x100 with imm=0x0004 → pred_taken=0, pred_target=0x104, if_beq=1, counters 0.
2. **Training and saturation.** Resolve the same beq (pc 0x100) taken 3× with ex_pred_taken matching the current prediction → first resolve mispredicts (redirect_pc=0x114, mispredict_count=1); after the 2nd resolve, IF at 0x100 predicts taken, target 0x114; counter saturates at 3; branch_count=3.
3. **Jump target.** j at pc 0x00400020, instr[25:0]=0x0100040 → pred_taken=1, pred_target=0x00400100; no BHT change.
4. **Squash window.** Mispredict in cycle N (bne, pc 0x200, actual not-taken) → redirect_valid=1 only in cycle N+1, redirect_pc=0x204; a valid mispredicting EX input in cycle N+1 produces no redirect and no count.
5. **Collision and counter saturation.** Same-index IF read and EX update in one cycle → IF shows the old prediction, the next cycle shows the new one. Force STAT_W=4 and issue 20 resolves → branch_count holds at 15.
6. **Mid-redirect reset.** Assert rst on the cycle redirect_valid=1 → redirect_valid=0 next cycle; all BHT entries read weakly-not-taken.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared decode constants, result types and saturating-counter helpers
// for the branch predictor.
package branch_pkg;

    localparam logic [5:0] OP_RTYPE      = 6'b000000;
    localparam logic [5:0] OP_J          = 6'b000010;
    localparam logic [5:0] OP_JAL        = 6'b000011;
    localparam logic [5:0] OP_BEQ        = 6'b000100;
    localparam logic [5:0] OP_BNE        = 6'b000101;
    localparam logic [5:0] FUNCT_SYSCALL = 6'b001100;

    // IF-stage decode result
    typedef struct packed {
        logic branch;
        logic jump;
        logic ecall;
        logic beq;
        logic bne;
    } decode_t;

    // Weakly-not-taken: one below the taken threshold
    function automatic int unsigned ctrInit(input int unsigned w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

    // Saturating increment for a w-bit counter
    function automatic int unsigned ctrInc(input int unsigned v, input int unsigned w);
        return (v == ((32'd1 << w) - 32'd1)) ? v : v + 32'd1;
    endfunction

    // Saturating decrement
    function automatic int unsigned ctrDec(input int unsigned v);
        return (v == 32'd0) ? v : v - 32'd1;
    endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// IF/EX pipeline-side signal bundle of the branch predictor.
// master = pipeline, slave = predictor.
interface branch_predict_unit_if #(
    parameter int STAT_W = 16
);
    logic              if_valid;
    logic [31:0]       if_pc;
    logic [31:0]       if_instr;
    logic              if_branch;
    logic              if_jump;
    logic              if_ecall;
    logic              if_beq;
    logic              if_bne;
    logic              pred_taken;
    logic [31:0]       pred_target;
    logic              ex_valid;
    logic              ex_branch;
    logic [31:0]       ex_pc;
    logic              ex_pred_taken;
    logic              ex_taken;
    logic [31:0]       ex_target;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic [STAT_W-1:0] branch_count;
    logic [STAT_W-1:0] mispredict_count;

    modport master (
        output if_valid, if_pc, if_instr,
        output ex_valid, ex_branch, ex_pc, ex_pred_taken, ex_taken, ex_target,
        input  if_branch, if_jump, if_ecall, if_beq, if_bne, pred_taken, pred_target,
        input  redirect_valid, redirect_pc, branch_count, mispredict_count
    );

    modport slave (
        input  if_valid, if_pc, if_instr,
        input  ex_valid, ex_branch, ex_pc, ex_pred_taken, ex_taken, ex_target,
        output if_branch, if_jump, if_ecall, if_beq, if_bne, pred_taken, pred_target,
        output redirect_valid, redirect_pc, branch_count, mispredict_count
    );
endinterface

// File: rtl/bht_table.sv
// Branch history table: DEPTH saturating counters, async read of the
// taken bit, synchronous trained write, single-cycle reset of all entries.
module bht_table
    import branch_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int CTR_W = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(DEPTH)-1:0] rdIdx,
    output logic                     rdTaken,
    input  logic                     wrEn,
    input  logic [$clog2(DEPTH)-1:0] wrIdx,
    input  logic                     wrTaken
);
    logic [CTR_W-1:0] ctr [DEPTH];

    // Read returns the pre-update value, so a same-cycle write is not visible
    assign rdTaken = ctr[rdIdx][CTR_W-1];

    // Reset every entry to weakly-not-taken, else train the addressed entry
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                ctr[i] <= CTR_W'(ctrInit(CTR_W));
        end else if (wrEn) begin
            ctr[wrIdx] <= wrTaken ? CTR_W'(ctrInc(32'(ctr[wrIdx]), CTR_W))
                                  : CTR_W'(ctrDec(32'(ctr[wrIdx])));
        end
    end
endmodule

// File: rtl/branch_predict_unit.sv
// Branch/jump decode and prediction in IF, BHT training, one-cycle
// mispredict redirect and saturating statistics from EX.
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int BHT_DEPTH = 64,
    parameter int CTR_W     = 2,
    parameter int STAT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_predict_unit_if.slave bus
);
    localparam int IDX_W = $clog2(BHT_DEPTH);

    decode_t           dec;
    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [31:0]       pc4;
    logic [31:0]       brTarget;
    logic [31:0]       jTarget;
    logic              bhtTaken;
    logic              predTaken;
    logic [31:0]       predTarget;
    logic              exLive;
    logic              train;
    logic              mispredict;
    logic              redirectValid;
    logic [31:0]       redirectPc;
    logic [STAT_W-1:0] branchCount;
    logic [STAT_W-1:0] mispredictCount;

    assign opcode   = bus.if_instr[31:26];
    assign funct    = bus.if_instr[5:0];
    assign pc4      = bus.if_pc + 32'd4;
    assign brTarget = pc4 + {{14{bus.if_instr[15]}}, bus.if_instr[15:0], 2'b00};
    assign jTarget  = {pc4[31:28], bus.if_instr[25:0], 2'b00};

    // Decode the fetched word; everything stays low without a valid fetch
    always_comb begin
        dec = '0;
        if (bus.if_valid) begin
            dec.beq   = (opcode == OP_BEQ);
            dec.bne   = (opcode == OP_BNE);
            dec.jump  = (opcode == OP_J) || (opcode == OP_JAL);
            dec.ecall = (opcode == OP_RTYPE) && (funct == FUNCT_SYSCALL);
        end
        dec.branch = dec.beq | dec.bne;
    end

    bht_table #(
        .DEPTH (BHT_DEPTH),
        .CTR_W (CTR_W)
    ) uBht (
        .clk     (clk),
        .rst     (rst),
        .rdIdx   (bus.if_pc[IDX_W+1:2]),
        .rdTaken (bhtTaken),
        .wrEn    (train),
        .wrIdx   (bus.ex_pc[IDX_W+1:2]),
        .wrTaken (bus.ex_taken)
    );

    // Next-PC prediction: jumps always taken, branches follow the BHT,
    // syscall and everything else fall through
    always_comb begin
        predTaken  = 1'b0;
        predTarget = pc4;
        if (dec.jump) begin
            predTaken  = 1'b1;
            predTarget = jTarget;
        end else if (dec.branch && bhtTaken) begin
            predTaken  = 1'b1;
            predTarget = brTarget;
        end
    end

    // EX input is wrong-path while a redirect is being issued
    assign exLive     = bus.ex_valid & ~redirectValid;
    assign train      = exLive & bus.ex_branch;
    assign mispredict = exLive & (bus.ex_pred_taken != bus.ex_taken);

    // Redirect register: one-cycle pulse, reset wins over a pending redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            redirectValid <= 1'b0;
            redirectPc    <= '0;
        end else begin
            redirectValid <= mispredict;
            if (mispredict)
                redirectPc <= bus.ex_taken ? bus.ex_target : bus.ex_pc + 32'd4;
        end
    end

    // Saturating statistics over conditional branches only
    always_ff @(posedge clk) begin
        if (rst) begin
            branchCount     <= '0;
            mispredictCount <= '0;
        end else if (train) begin
            if (branchCount != '1)
                branchCount <= branchCount + STAT_W'(1);
            if (mispredict && mispredictCount != '1)
                mispredictCount <= mispredictCount + STAT_W'(1);
        end
    end

    assign bus.if_branch        = dec.branch;
    assign bus.if_jump          = dec.jump;
    assign bus.if_ecall         = dec.ecall;
    assign bus.if_beq           = dec.beq;
    assign bus.if_bne           = dec.bne;
    assign bus.pred_taken       = predTaken;
    assign bus.pred_target      = predTarget;
    assign bus.redirect_valid   = redirectValid;
    assign bus.redirect_pc      = redirectPc;
    assign bus.branch_count     = branchCount;
    assign bus.mispredict_count = mispredictCount;
endmodule
